pipe_share_gen: RTL and testbench



---
 rtl/masked_pkg.sv | 25 ++
 rtl/mask_lfsr.sv | 51 +++++
 rtl/pipe_share_gen.sv | 125 ++++++++++++
 tb/tb_pipe_share_gen.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/masked_pkg.sv
`default_nettype none
// ============================================================================
// Module      : masked_pkg
// Description : Shared constants and types for the masked adder datapath
//               (share generator on the front, share recombiner on the back).
// Revision    : 1.0 - initial release
// ============================================================================
package masked_pkg;

    // Default operand width used by both sides of the masked adder
    localparam int c_DEFAULT_N = 4;

    // Mask generator defaults: x^16 + x^14 + x^13 + x^11 + 1, Galois form
    localparam int              c_LFSR_W = 16;
    localparam logic [15:0]     c_TAPS   = 16'hB400;
    localparam logic [15:0]     c_SEED   = 16'hACE1;

    // One Boolean-shared value: s0 ^ s1 recovers the plain value
    typedef struct packed {
        logic [c_DEFAULT_N-1:0] s0;
        logic [c_DEFAULT_N-1:0] s1;
    } share_pair_t;

endpackage : masked_pkg
`default_nettype wire

// File: rtl/mask_lfsr.sv
`default_nettype none
// ============================================================================
// Module      : mask_lfsr
// Description : Galois LFSR producing fresh mask bits. Advances one step per
//               enable, can be reloaded; an all-zero load is replaced by SEED
//               so the register can never lock up at zero.
// Revision    : 1.0 - initial release
// ============================================================================
module mask_lfsr #(
    parameter int              W      = 16,
    parameter int              MASK_W = 8,
    parameter logic [W-1:0]    TAPS   = 16'hB400,
    parameter logic [W-1:0]    SEED   = 16'hACE1
) (
    input  logic              clk1,
    input  logic              rst,
    input  logic              en,
    input  logic              load,
    input  logic [W-1:0]      load_value,
    output logic [MASK_W-1:0] mask
);

    logic [W-1:0] r_state;
    logic [W-1:0] w_step;
    logic [W-1:0] w_load_value;

    // One Galois shift: feedback bit is the outgoing LSB
    always_comb begin
        w_step = {1'b0, r_state[W-1:1]} ^ (r_state[0] ? TAPS : {W{1'b0}});
    end

    // Zero is never a legal state, substitute the seed
    always_comb begin
        w_load_value = (load_value == {W{1'b0}}) ? SEED : load_value;
    end

    // State register: load wins over advance, hold otherwise
    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) begin
            r_state <= SEED;
        end else if (load) begin
            r_state <= w_load_value;
        end else if (en) begin
            r_state <= w_step;
        end
    end

    assign mask = r_state[MASK_W-1:0];

endmodule : mask_lfsr
`default_nettype wire

// File: rtl/pipe_share_gen.sv
`default_nettype none
// ============================================================================
// Module      : pipe_share_gen
// Description : Masking front end for the pipelined masked adder. Splits
//               operands a and b into two Boolean shares each using fresh
//               LFSR randomness and delivers them through a 2-stage
//               valid/ready pipeline.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_share_gen
    import masked_pkg::*;
#(
    parameter int                  N      = c_DEFAULT_N,
    parameter int                  LFSR_W = c_LFSR_W,
    parameter logic [LFSR_W-1:0]   TAPS   = c_TAPS,
    parameter logic [LFSR_W-1:0]   SEED   = c_SEED
) (
    input  logic              clk1,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [N-1:0]      a,
    input  logic [N-1:0]      b,
    input  logic              c_in,
    input  logic              seed_load,
    input  logic [LFSR_W-1:0] seed,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [N-1:0]      a0,
    output logic [N-1:0]      a1,
    output logic [N-1:0]      b0,
    output logic [N-1:0]      b1,
    output logic              c_out
);

    // Reject configurations that cannot supply two independent masks or
    // that would start the LFSR in its stuck-at-zero state
    if (2 * N > LFSR_W) begin : g_bad_width
        $error("pipe_share_gen: 2*N must not exceed LFSR_W");
    end
    if (SEED == {LFSR_W{1'b0}}) begin : g_bad_seed
        $error("pipe_share_gen: SEED must be nonzero");
    end

    logic [2*N-1:0] w_mask;
    logic           w_s2_free;
    logic           w_s1_move;
    logic           w_accept;

    logic           r_s1_valid;
    logic [N-1:0]   r_s1_a;
    logic [N-1:0]   r_s1_b;
    logic           r_s1_c;
    logic [N-1:0]   r_s1_ma;
    logic [N-1:0]   r_s1_mb;

    // Mask source; advances only on an accepted operand so masks never repeat
    // across consecutive transactions
    mask_lfsr #(
        .W      (LFSR_W),
        .MASK_W (2 * N),
        .TAPS   (TAPS),
        .SEED   (SEED)
    ) u_mask_lfsr (
        .clk1       (clk1),
        .rst        (rst),
        .en         (w_accept),
        .load       (seed_load),
        .load_value (seed),
        .mask       (w_mask)
    );

    // Handshake: built only from registered valids and out_ready, so there is
    // no combinational path from in_valid to either ready or valid
    always_comb begin
        w_s2_free = !out_valid || out_ready;
        w_s1_move = r_s1_valid && w_s2_free;
        in_ready  = !r_s1_valid || w_s1_move;
        w_accept  = in_valid && in_ready;
    end

    // Stage 1: capture operands together with the current (pre-advance) mask
    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_a     <= '0;
            r_s1_b     <= '0;
            r_s1_c     <= 1'b0;
            r_s1_ma    <= '0;
            r_s1_mb    <= '0;
        end else if (w_accept) begin
            r_s1_valid <= 1'b1;
            r_s1_a     <= a;
            r_s1_b     <= b;
            r_s1_c     <= c_in;
            r_s1_ma    <= w_mask[N-1:0];
            r_s1_mb    <= w_mask[2*N-1:N];
        end else if (w_s1_move) begin
            r_s1_valid <= 1'b0;
        end
    end

    // Stage 2: form the shares; only masked values reach the output registers
    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            a0        <= '0;
            a1        <= '0;
            b0        <= '0;
            b1        <= '0;
            c_out     <= 1'b0;
        end else if (w_s1_move) begin
            out_valid <= 1'b1;
            a0        <= r_s1_ma;
            a1        <= r_s1_a ^ r_s1_ma;
            b0        <= r_s1_mb;
            b1        <= r_s1_b ^ r_s1_mb;
            c_out     <= r_s1_c;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule : pipe_share_gen
`default_nettype wire

// File: tb/tb_pipe_share_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_share_gen
// Description : Scoreboard bench for pipe_share_gen. The driver pushes the
//               expected share set for every accepted operand; a monitor
//               compares the head of the queue whenever out_valid is high
//               and pops it on each output transfer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_share_gen;

    localparam int          c_N    = 4;
    localparam int          c_W    = 16;
    localparam logic [15:0] c_TAPS = 16'hB400;
    localparam logic [15:0] c_SEED = 16'hACE1;

    typedef struct packed {
        logic [c_N-1:0] a0;
        logic [c_N-1:0] a1;
        logic [c_N-1:0] b0;
        logic [c_N-1:0] b1;
        logic           c;
    } exp_t;

    logic           clk1;
    logic           rst;
    logic           in_valid;
    logic           in_ready;
    logic [c_N-1:0] a;
    logic [c_N-1:0] b;
    logic           c_in;
    logic           seed_load;
    logic [c_W-1:0] seed;
    logic           out_valid;
    logic           out_ready;
    logic [c_N-1:0] a0;
    logic [c_N-1:0] a1;
    logic [c_N-1:0] b0;
    logic [c_N-1:0] b1;
    logic           c_out;

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t sb_q[$];
    logic [c_W-1:0] lfsr_m;
    logic           acc;

    pipe_share_gen #(
        .N      (c_N),
        .LFSR_W (c_W),
        .TAPS   (c_TAPS),
        .SEED   (c_SEED)
    ) dut (
        .clk1      (clk1),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .c_in      (c_in),
        .seed_load (seed_load),
        .seed      (seed),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .a0        (a0),
        .a1        (a1),
        .b0        (b0),
        .b1        (b1),
        .c_out     (c_out)
    );

    initial clk1 = 1'b0;
    always #5 clk1 = ~clk1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] model_step(input logic [15:0] s);
        logic [15:0] r;
        r = s >> 1;
        if (s[0]) r = r ^ c_TAPS;
        return r;
    endfunction

    // Drive one cycle of inputs at the falling edge; the transfer decision is
    // taken once in_ready has settled, and the model LFSR follows it
    task automatic drive(input logic v, input logic [3:0] av, input logic [3:0] bv,
                         input logic cv, input logic ordy, input logic sl,
                         input logic [15:0] sd, output logic accepted);
        exp_t e;
        @(negedge clk1);
        in_valid  = v;
        a         = av;
        b         = bv;
        c_in      = cv;
        out_ready = ordy;
        seed_load = sl;
        seed      = sd;
        #1;
        accepted = v && in_ready;
        if (accepted) begin
            e.a0 = lfsr_m[3:0];
            e.a1 = av ^ lfsr_m[3:0];
            e.b0 = lfsr_m[7:4];
            e.b1 = bv ^ lfsr_m[7:4];
            e.c  = cv;
            sb_q.push_back(e);
        end
        if (sl)            lfsr_m = (sd == 16'h0) ? c_SEED : sd;
        else if (accepted) lfsr_m = model_step(lfsr_m);
    endtask

    task automatic idle(input logic ordy);
        logic dummy;
        drive(1'b0, 4'h0, 4'h0, 1'b0, ordy, 1'b0, 16'h0, dummy);
    endtask

    // Keep offering one operand until it is taken (bounded)
    task automatic send(input logic [3:0] av, input logic [3:0] bv, input logic cv);
        logic ok;
        int   tries;
        ok = 1'b0;
        tries = 0;
        while (!ok && tries < 50) begin
            drive(1'b1, av, bv, cv, 1'b1, 1'b0, 16'h0, ok);
            tries++;
        end
        if (!ok) check("send_timeout", 32'd0, 32'd1);
    endtask

    // Wait for the pipeline to empty with out_ready high (bounded)
    task automatic drain();
        int cyc;
        cyc = 0;
        while ((sb_q.size() != 0 || out_valid) && cyc < 100) begin
            idle(1'b1);
            cyc++;
        end
        check("drain_empty", sb_q.size(), 32'd0);
    endtask

    // Monitor: every visible share set must match the scoreboard head;
    // it stays the head (so must stay stable) until out_ready takes it
    always @(negedge clk1) begin
        exp_t e;
        #2;
        if (!rst && out_valid) begin
            if (sb_q.size() == 0) begin
                check("unexpected_out_valid", 32'd1, 32'd0);
            end else begin
                e = sb_q[0];
                check("share_set", {15'd0, a0, a1, b0, b1, c_out}, {15'd0, e});
                if (out_ready) void'(sb_q.pop_front());
            end
        end
    end

    initial begin
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        c_in      = 1'b0;
        out_ready = 1'b1;
        seed_load = 1'b0;
        seed      = '0;
        lfsr_m    = c_SEED;
        rst       = 1'b1;
        repeat (3) @(negedge clk1);
        #3;
        // Reset state
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_shares", {a0, a1, b0, b1, c_out}, 17'd0);
        check("rst_in_ready", in_ready, 1'b1);
        @(negedge clk1);
        rst = 1'b0;

        // 1: single transaction, latency of two edges
        drive(1'b1, 4'hA, 4'h3, 1'b1, 1'b1, 1'b0, 16'h0, acc);
        check("t1_accept", acc, 1'b1);
        idle(1'b1);
        check("t1_not_yet_valid", out_valid, 1'b0);
        idle(1'b1);
        check("t1_valid", out_valid, 1'b1);
        check("t1_a0", a0, 4'h1);
        check("t1_a1", a1, 4'hB);
        check("t1_b0", b0, 4'hE);
        check("t1_b1", b1, 4'hD);
        check("t1_c_out", c_out, 1'b1);
        drain();
        // Second mask comes from the advanced state 16'hE270
        send(4'h0, 4'h0, 1'b0);
        drain();

        // 2: eight back-to-back operands
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 4'(i * 3 + 1), 4'(15 - i * 2), 1'(i), 1'b1, 1'b0, 16'h0, acc);
            check("t2_accept", acc, 1'b1);
        end
        drain();

        // 3: stall downstream, third operand must be refused
        drive(1'b1, 4'h5, 4'h6, 1'b0, 1'b0, 1'b0, 16'h0, acc);
        check("t3_acc0", acc, 1'b1);
        drive(1'b1, 4'h7, 4'h8, 1'b1, 1'b0, 1'b0, 16'h0, acc);
        check("t3_acc1", acc, 1'b1);
        drive(1'b1, 4'h9, 4'hC, 1'b0, 1'b0, 1'b0, 16'h0, acc);
        check("t3_acc2_refused", acc, 1'b0);
        check("t3_in_ready_low", in_ready, 1'b0);
        repeat (3) idle(1'b0);
        send(4'h9, 4'hC, 1'b0);
        drain();

        // 4: zero seed load falls back to SEED; load alongside an accept
        drive(1'b0, 4'h0, 4'h0, 1'b0, 1'b1, 1'b1, 16'h0000, acc);
        send(4'hA, 4'h3, 1'b1);
        drain();
        drive(1'b1, 4'h4, 4'h2, 1'b0, 1'b1, 1'b1, 16'h1234, acc);
        check("t4_accept_with_load", acc, 1'b1);
        send(4'hF, 4'h0, 1'b1);
        drain();

        // 5: reset with both stages full
        drive(1'b1, 4'h1, 4'h2, 1'b1, 1'b0, 1'b0, 16'h0, acc);
        drive(1'b1, 4'h3, 4'h4, 1'b0, 1'b0, 1'b0, 16'h0, acc);
        idle(1'b0);
        #4;
        rst = 1'b1;
        #1;
        check("t5_rst_out_valid", out_valid, 1'b0);
        sb_q.delete();
        lfsr_m = c_SEED;
        @(negedge clk1);
        rst = 1'b0;
        #1;
        check("t5_post_in_ready", in_ready, 1'b1);
        check("t5_post_out_valid", out_valid, 1'b0);
        send(4'h6, 4'h9, 1'b1);
        drain();

        // 6: random operands with random backpressure
        for (int i = 0; i < 400; i++) begin
            logic ok;
            logic [3:0] ra, rb;
            int tries;
            ra = 4'($urandom);
            rb = 4'($urandom);
            ok = 1'b0;
            tries = 0;
            while (!ok && tries < 50) begin
                drive(1'b1, ra, rb, 1'($urandom), 1'($urandom), 1'b0, 16'h0, ok);
                tries++;
            end
            if (!ok) check("t6_send_timeout", 32'd0, 32'd1);
        end
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_pipe_share_gen
`default_nettype wire
